// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core requesters, main memory and mem_arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) ();
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_write_enable;
  logic              mem_read_enable;
  logic [DATA_W-1:0] mem_data_out;

  logic              busy;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    output i_ack, i_rdata, d_ack, d_rdata,
           mem_address, mem_data_in, mem_write_enable, mem_read_enable, busy
  );

  // Requester / memory side
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
    input  i_ack, i_rdata, d_ack, d_rdata,
           mem_address, mem_data_in, mem_write_enable, mem_read_enable, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and the data path; one outstanding transaction, all outputs registered.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t state;
  logic   last_grant_d;   // 1: last grant went to the data port
  logic   pick_d_c;

  // Data wins when alone, or on a tie when fetch was served last
  assign pick_d_c = bus.d_req & (~bus.i_req | ~last_grant_d);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      last_grant_d         <= 1'b1;
      bus.i_ack            <= 1'b0;
      bus.d_ack            <= 1'b0;
      bus.i_rdata          <= '0;
      bus.d_rdata          <= '0;
      bus.mem_address      <= '0;
      bus.mem_data_in      <= '0;
      bus.mem_write_enable <= 1'b0;
      bus.mem_read_enable  <= 1'b0;
      bus.busy             <= 1'b0;
    end else begin
      bus.i_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req || bus.d_req) begin
            last_grant_d <= pick_d_c;
            bus.busy     <= 1'b1;
            state        <= ISSUE;
            if (pick_d_c) begin
              bus.mem_address      <= ADDR_W'(bus.d_addr);
              bus.mem_data_in      <= DATA_W'(bus.d_wdata);
              bus.mem_write_enable <= bus.d_we;
              bus.mem_read_enable  <= ~bus.d_we;
            end else begin
              bus.mem_address      <= ADDR_W'(bus.i_addr);
              bus.mem_write_enable <= 1'b0;
              bus.mem_read_enable  <= 1'b1;
            end
          end
        end
        ISSUE: begin
          bus.mem_write_enable <= 1'b0;
          bus.mem_read_enable  <= 1'b0;
          if (bus.mem_write_enable) begin
            // Stores skip CAPTURE and acknowledge straight away
            bus.d_ack <= last_grant_d;
            bus.i_ack <= ~last_grant_d;
            state     <= DONE;
          end else begin
            state     <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (last_grant_d) begin
            bus.d_rdata <= DATA_W'(bus.mem_data_out);
            bus.d_ack   <= 1'b1;
          end else begin
            bus.i_rdata <= DATA_W'(bus.mem_data_out);
            bus.i_ack   <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a registered-output memory model.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [DATA_W-1:0] mem [1024];

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Single-port memory: write-through on write_enable, registered read data
  always @(posedge clk) begin
    if (bus.mem_write_enable) mem[bus.mem_address] = bus.mem_data_in;
    if (bus.mem_read_enable)  bus.mem_data_out <= mem[bus.mem_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Mutual exclusion of enables and acks on every cycle out of reset
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      check("excl_en",  32'(bus.mem_read_enable & bus.mem_write_enable), 32'd0);
      check("excl_ack", 32'(bus.i_ack & bus.d_ack), 32'd0);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({bus.busy, bus.i_ack, bus.d_ack,
                              bus.mem_read_enable, bus.mem_write_enable}), 32'd0);
    check({tag, "_addr"}, 32'(bus.mem_address), 32'd0);
    check({tag, "_din"},  32'(bus.mem_data_in), 32'd0);
    check({tag, "_rd"},   {bus.i_rdata, bus.d_rdata}, 32'd0);
  endtask

  // Called just after the negedge preceding the sampling edge. k counts negedges
  // after that: enables visible at k=1, read ack at k=3, store ack at k=2.
  task automatic wait_ack(input bit is_d, input bit is_wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rd,
                          input bit drop_early);
    logic [DATA_W-1:0] other_rd;
    bit seen;
    seen     = 1'b0;
    other_rd = is_d ? bus.i_rdata : bus.d_rdata;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("issue_en", 32'({bus.mem_read_enable, bus.mem_write_enable}),
              is_wr ? 32'd1 : 32'd2);
        check("issue_addr", 32'(bus.mem_address), 32'(addr));
        if (is_wr) check("issue_wdata", 32'(bus.mem_data_in), 32'(wdata));
        if (drop_early) begin
          bus.i_req = 1'b0;
          bus.d_req = 1'b0;
        end
      end
      check("wrong_ack", 32'(is_d ? bus.i_ack : bus.d_ack), 32'd0);
      if (is_d ? bus.d_ack : bus.i_ack) begin
        check("latency", 32'(k), is_wr ? 32'd2 : 32'd3);
        if (!is_wr) check("rdata", 32'(is_d ? bus.d_rdata : bus.i_rdata), 32'(exp_rd));
        check("other_rdata", 32'(is_d ? bus.i_rdata : bus.d_rdata), 32'(other_rd));
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input bit is_d, input bit is_wr, input logic [ADDR_W-1:0] addr,
                     input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rd,
                     input bit drop_early);
    @(negedge clk);
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_we = is_wr; bus.d_addr = addr; bus.d_wdata = wdata;
    end else begin
      bus.i_req = 1'b1; bus.i_addr = addr;
    end
    wait_ack(is_d, is_wr, addr, wdata, exp_rd, drop_early);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acks;
    int last_k;
    bit done;
    for (int a = 0; a < 1024; a++) mem[a] = 16'h0000;
    mem[10'h000] = 16'h8000;
    mem[10'h3FF] = 16'h7FFF;
    mem[10'h010] = 16'h0111;
    mem[10'h020] = 16'h0222;
    mem[10'h030] = 16'h1234;

    reset = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 10'h000;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset held with a pending fetch: nothing moves
    repeat (3) @(negedge clk);
    check_all_zero("reset_hold");

    // Release: pending fetch is granted on the first edge
    reset = 1'b1;
    wait_ack(1'b0, 1'b0, 10'h000, 16'h0000, 16'h8000, 1'b0);

    // Store -200 then load it back
    txn(1'b1, 1'b1, 10'h005, 16'hFF38, 16'h0000, 1'b0);
    check("mem_005", 32'(mem[10'h005]), 32'h0000FF38);
    txn(1'b1, 1'b0, 10'h005, 16'h0000, 16'hFF38, 1'b0);

    // Address extremes; the other port's rdata must not move
    txn(1'b0, 1'b0, 10'h3FF, 16'h0000, 16'h7FFF, 1'b0);
    txn(1'b1, 1'b0, 10'h000, 16'h0000, 16'h8000, 1'b0);

    // Continuous contention: acks alternate I, D, I, D every 4 cycles
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 10'h010;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'h020;
    n_acks = 0; last_k = 0; done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) begin
        check("rr_order", 32'(bus.d_ack), 32'(n_acks % 2));
        if (n_acks > 0) check("rr_gap", 32'(k - last_k), 32'd4);
        if (bus.d_ack) check("rr_drd", 32'(bus.d_rdata), 32'h0222);
        else           check("rr_ird", 32'(bus.i_rdata), 32'h0111);
        last_k = k;
        n_acks++;
        if (n_acks == 4) begin
          bus.i_req = 1'b0;
          bus.d_req = 1'b0;
          done = 1'b1;
          break;
        end
      end
    end
    if (!done) check("rr_timeout", 32'(n_acks), 32'd4);

    // Reset during CAPTURE of a load aborts it without an ack
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 10'h030;
    repeat (2) @(negedge clk);
    check("cap_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    check_all_zero("mid_reset");
    repeat (2) @(negedge clk);
    check("abort_ack", 32'({bus.i_ack, bus.d_ack, bus.busy}), 32'd0);
    reset = 1'b1;
    wait_ack(1'b1, 1'b0, 10'h030, 16'h0000, 16'h1234, 1'b0);

    // One-cycle req pulse still completes the store
    txn(1'b1, 1'b1, 10'h0A0, 16'h0042, 16'h0000, 1'b1);
    txn(1'b1, 1'b0, 10'h0A0, 16'h0000, 16'h0042, 1'b0);
    @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
